// File: rtl/pwm_car_pkg.sv
// pwm_car_pkg: shared constants for the PWM car AXI4-Lite peripheral.
//   - Register word indices (address bits [3:2]) for the four software registers.
//   - CTRL register bit positions.
//   - AXI response code and a byte-strobe merge helper.
package pwm_car_pkg;

  // Word index of each register (byte offset >> 2)
  localparam logic [1:0] REG_PERIOD = 2'd0;
  localparam logic [1:0] REG_DUTY_L = 2'd1;
  localparam logic [1:0] REG_DUTY_R = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // CTRL bit positions; bits [31:3] are plain storage
  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_DIR_L = 1;
  localparam int unsigned CTRL_DIR_R = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Replace only the bytes of old_val whose strobe bit is set
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_car_pwm_chan.sv
// pwm_car_pwm_chan: one PWM channel -- compares the shared period counter
// against this channel's duty value and registers the result.
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   en_i    channel may drive high (enable set and period non-zero)
//   cnt_i   shared period counter
//   duty_i  duty value in counter ticks
//   pwm_o   registered PWM output
module pwm_car_pwm_chan #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] cnt_i,
  input  logic [Width-1:0] duty_i,
  output logic             pwm_o
);

  logic pwm_q;
  logic pwm_d;

  // duty >= period never fails the compare, so the output stays high
  always_comb begin
    pwm_d = en_i && (cnt_i < duty_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_car_axil_slave.sv
// pwm_car_axil_slave: AXI4-Lite responder holding PERIOD, DUTY_L, DUTY_R and
// CTRL, plus a shared period counter feeding two PWM channels.
//   ACLK / ARESETN           clock, asynchronous active-low reset
//   S_AXI_AW* / W* / B*      write address, data and response channels
//   S_AXI_AR* / R*           read address and data channels
//   motor_pwm[1:0]           {right, left} PWM outputs (registered)
//   motor_dir[1:0]           {right, left} direction outputs (registered)
// Build option: define PWM_CAR_SHADOW_EN to compare against shadow copies of
// PERIOD/DUTY_L/DUTY_R that only update at the period boundary or while idle.
module pwm_car_axil_slave
  import pwm_car_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [1:0]                      motor_pwm,
  output logic [1:0]                      motor_dir
);

  logic [31:0] regs_q [4];
  logic        bvalid_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        wr_accept;
  logic        rd_accept;
  logic [1:0]  wr_sel;
  logic [1:0]  rd_sel;

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic        cnt_run;
  logic        cnt_wrap;
  logic [31:0] period_use;
  logic [31:0] duty_l_use;
  logic [31:0] duty_r_use;
  logic [1:0]  dir_q;
  logic        pwm_l;
  logic        pwm_r;

  // Protection bits and byte-lane address bits carry no meaning here
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_sel = S_AXI_AWADDR[3:2];
  assign rd_sel = S_AXI_ARADDR[3:2];

  // AW and W are only ever taken together. Readies are qualified with
  // ARESETN so they fall as soon as reset is asserted.
  assign wr_accept = ARESETN && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
  assign rd_accept = ARESETN && S_AXI_ARVALID && !rvalid_q;

  assign S_AXI_AWREADY = wr_accept;
  assign S_AXI_WREADY  = wr_accept;
  assign S_AXI_ARREADY = rd_accept;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

  // Register file
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (wr_accept) begin
      regs_q[wr_sel] <= apply_wstrb(regs_q[wr_sel], S_AXI_WDATA, S_AXI_WSTRB);
    end
  end

  // Write response; a fresh acceptance wins over a BREADY clear
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bvalid_q <= 1'b0;
    end else if (wr_accept) begin
      bvalid_q <= 1'b1;
    end else if (S_AXI_BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  // Read data is captured from the pre-write register contents, so a
  // same-cycle read and write of one register returns the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (rd_accept) begin
      rvalid_q <= 1'b1;
      rdata_q  <= regs_q[rd_sel];
    end else if (S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

`ifdef PWM_CAR_SHADOW_EN
  logic [31:0] period_sh_q;
  logic [31:0] duty_l_sh_q;
  logic [31:0] duty_r_sh_q;

  // Load at the last tick of a period, or every cycle while the counter idles
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      period_sh_q <= '0;
      duty_l_sh_q <= '0;
      duty_r_sh_q <= '0;
    end else if (!cnt_run || cnt_wrap) begin
      period_sh_q <= regs_q[REG_PERIOD];
      duty_l_sh_q <= regs_q[REG_DUTY_L];
      duty_r_sh_q <= regs_q[REG_DUTY_R];
    end
  end

  assign period_use = period_sh_q;
  assign duty_l_use = duty_l_sh_q;
  assign duty_r_use = duty_r_sh_q;
`else
  assign period_use = regs_q[REG_PERIOD];
  assign duty_l_use = regs_q[REG_DUTY_L];
  assign duty_r_use = regs_q[REG_DUTY_R];
`endif

  // Shared counter: 0..period-1. ">=" also recovers if PERIOD shrinks below cnt.
  always_comb begin
    cnt_run  = regs_q[REG_CTRL][CTRL_EN] && (period_use != '0);
    cnt_wrap = cnt_q >= (period_use - 32'd1);
    cnt_d    = '0;
    if (cnt_run && !cnt_wrap) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_q <= '0;
      dir_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= {regs_q[REG_CTRL][CTRL_DIR_R], regs_q[REG_CTRL][CTRL_DIR_L]};
    end
  end

  pwm_car_pwm_chan #(
    .Width (32)
  ) u_chan_l (
    .clk_i  (ACLK),
    .rst_ni (ARESETN),
    .en_i   (cnt_run),
    .cnt_i  (cnt_q),
    .duty_i (duty_l_use),
    .pwm_o  (pwm_l)
  );

  pwm_car_pwm_chan #(
    .Width (32)
  ) u_chan_r (
    .clk_i  (ACLK),
    .rst_ni (ARESETN),
    .en_i   (cnt_run),
    .cnt_i  (cnt_q),
    .duty_i (duty_r_use),
    .pwm_o  (pwm_r)
  );

  assign motor_pwm = {pwm_r, pwm_l};
  assign motor_dir = dir_q;

endmodule

// File: tb/tb_pwm_car_axil_slave.sv
// Self-checking bench for pwm_car_axil_slave: register readback against a
// word-array model, handshake timing, and PWM duty counted over windows.
module tb_pwm_car_axil_slave;

  logic        tb_ACLK;
  logic        ARESETN;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [1:0]  motor_pwm;
  logic [1:0]  motor_dir;

  int checks   = 0;
  int failures = 0;
  bit bus_err  = 1'b0;

  logic [31:0] model [4];

  pwm_car_axil_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4)
  ) dut (
    .ACLK          (tb_ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .motor_pwm     (motor_pwm),
    .motor_dir     (motor_dir)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  initial begin
    #3ms;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Model of a byte-strobed store
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output bit ok);
    int n;
    ok = 1'b0;
    resp = 2'b11;
    @(negedge tb_ACLK);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    #1;
    n = 0;
    while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 50) begin
      @(negedge tb_ACLK); #1; n++;
    end
    if (n < 50) begin
      @(posedge tb_ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      n = 0;
      while (!S_AXI_BVALID && n < 50) begin @(negedge tb_ACLK); n++; end
      if (S_AXI_BVALID) begin resp = S_AXI_BRESP; ok = 1'b1; end
      @(posedge tb_ACLK); #1;
    end else begin
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit ok);
    int n;
    ok = 1'b0;
    resp = 2'b11;
    data = 'x;
    @(negedge tb_ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    #1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(negedge tb_ACLK); #1; n++; end
    if (n < 50) begin
      @(posedge tb_ACLK); #1;
      S_AXI_ARVALID = 1'b0;
      n = 0;
      while (!S_AXI_RVALID && n < 50) begin @(negedge tb_ACLK); n++; end
      if (S_AXI_RVALID) begin data = S_AXI_RDATA; resp = S_AXI_RRESP; ok = 1'b1; end
      @(posedge tb_ACLK); #1;
    end else begin
      S_AXI_ARVALID = 1'b0;
    end
  endtask

  // Configuration write: keeps the model in step, flags bus trouble in bus_err
  task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
    logic [1:0] resp;
    bit ok;
    axi_write(addr, data, 4'hF, resp, ok);
    if (!ok || resp != 2'b00) bus_err = 1'b1;
    model[addr[3:2]] = data;
  endtask

  task automatic count_pwm(input int n, output int hl, output int hr);
    hl = 0; hr = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge tb_ACLK);
      if (motor_pwm[0]) hl++;
      if (motor_pwm[1]) hr++;
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    #495;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA,
         S_AXI_BRESP, S_AXI_RRESP, motor_pwm, motor_dir} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rdata=%h pwm=%b dir=%b bvalid=%b rvalid=%b want all 0",
               S_AXI_RDATA, motor_pwm, motor_dir, S_AXI_BVALID, S_AXI_RVALID);
    end
    #5 ARESETN = 1'b1;
  endtask

  task automatic test_plan_regs();
    logic [31:0] vals [4];
    logic [31:0] rd;
    logic [1:0]  resp;
    bit ok;
    vals[0] = 32'h0101FFFF; vals[1] = 32'habcd0001; vals[2] = 32'hdead0011; vals[3] = 32'hbeef0011;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), vals[i], 4'hF, resp, ok);
      model[i] = vals[i];
      checks++;
      if (!ok || resp !== 2'b00) begin
        failures++;
        $display("FAIL plan_bresp reg %0d got ok=%0d bresp=%b want ok=1 bresp=00", i, ok, resp);
      end
      axi_read(4'(i * 4), rd, resp, ok);
      checks++;
      if (!ok || rd !== vals[i]) begin
        failures++;
        $display("FAIL plan_readback reg %0d got %h want %h", i, rd, vals[i]);
      end
      checks++;
      if (resp !== 2'b00) begin
        failures++;
        $display("FAIL plan_rresp reg %0d got %b want 00", i, resp);
      end
    end
  endtask

  task automatic test_random_regs();
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] rd;
    logic [1:0]  resp;
    bit ok;
    for (int it = 0; it < 40; it++) begin
      addr = 4'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        data = $urandom;
        strb = 4'($urandom);
        axi_write(addr, data, strb, resp, ok);
        model[addr[3:2]] = merge(model[addr[3:2]], data, strb);
        checks++;
        if (!ok || resp !== 2'b00) begin
          failures++;
          $display("FAIL rand_write addr %h got ok=%0d bresp=%b want ok=1 bresp=00",
                   addr, ok, resp);
        end
      end else begin
        axi_read(addr, rd, resp, ok);
        checks++;
        if (!ok || rd !== model[addr[3:2]] || resp !== 2'b00) begin
          failures++;
          $display("FAIL rand_read addr %h got %h/%b want %h/00", addr, rd, resp, model[addr[3:2]]);
        end
      end
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd;
    logic [1:0]  resp;
    bit ok;
    cfg_write(4'h8, 32'h11223344);
    axi_write(4'h8, 32'h0000AB00, 4'b0010, resp, ok);
    model[2] = merge(model[2], 32'h0000AB00, 4'b0010);
    axi_read(4'h8, rd, resp, ok);
    checks++;
    if (!ok || rd !== 32'h1122AB44) begin
      failures++;
      $display("FAIL strobe_merge got %h want 1122ab44", rd);
    end
    checks++;
    if (bus_err !== 1'b0) begin
      failures++;
      $display("FAIL strobe_bus got bus_err=%0d want 0", bus_err);
    end
    bus_err = 1'b0;
  endtask

  task automatic test_pwm_basic();
    int hl, hr;
    cfg_write(4'hC, 32'h0);
    cfg_write(4'h0, 32'd10);
    cfg_write(4'h4, 32'd3);
    cfg_write(4'h8, 32'd10);
    cfg_write(4'hC, 32'h3);
    repeat (30) @(negedge tb_ACLK);
    count_pwm(20, hl, hr);
    checks++;
    if (hl !== 6) begin
      failures++;
      $display("FAIL pwm_left_duty got %0d high of 20 want 6", hl);
    end
    checks++;
    if (hr !== 20) begin
      failures++;
      $display("FAIL pwm_right_full got %0d high of 20 want 20", hr);
    end
    checks++;
    if (motor_dir !== 2'b01) begin
      failures++;
      $display("FAIL pwm_dir got %b want 01", motor_dir);
    end
    // Enable cleared: outputs drop, direction still follows CTRL
    cfg_write(4'hC, 32'h6);
    repeat (2) @(negedge tb_ACLK);
    count_pwm(12, hl, hr);
    checks++;
    if (hl !== 0 || hr !== 0 || motor_dir !== 2'b11) begin
      failures++;
      $display("FAIL pwm_disabled got hl=%0d hr=%0d dir=%b want 0 0 11", hl, hr, motor_dir);
    end
    // PERIOD 0 with enable set keeps outputs low
    cfg_write(4'h0, 32'd0);
    cfg_write(4'hC, 32'h1);
    repeat (4) @(negedge tb_ACLK);
    count_pwm(12, hl, hr);
    checks++;
    if (hl !== 0 || hr !== 0) begin
      failures++;
      $display("FAIL pwm_period0 got hl=%0d hr=%0d want 0 0", hl, hr);
    end
    checks++;
    if (bus_err !== 1'b0) begin
      failures++;
      $display("FAIL pwm_bus got bus_err=%0d want 0", bus_err);
    end
    bus_err = 1'b0;
  endtask

  task automatic test_pwm_random();
    int per, dl, dr, hl, hr, el, er;
    for (int it = 0; it < 6; it++) begin
      per = $urandom_range(1, 12);
      dl  = $urandom_range(0, 14);
      dr  = $urandom_range(0, 14);
      cfg_write(4'hC, 32'h0);
      cfg_write(4'h0, 32'(per));
      cfg_write(4'h4, 32'(dl));
      cfg_write(4'h8, 32'(dr));
      cfg_write(4'hC, 32'h1);
      repeat (40) @(negedge tb_ACLK);
      count_pwm(2 * per, hl, hr);
      el = 2 * ((dl < per) ? dl : per);
      er = 2 * ((dr < per) ? dr : per);
      checks++;
      if (hl !== el || hr !== er) begin
        failures++;
        $display("FAIL pwm_random per=%0d dl=%0d dr=%0d got hl=%0d hr=%0d want %0d %0d",
                 per, dl, dr, hl, hr, el, er);
      end
    end
    checks++;
    if (bus_err !== 1'b0) begin
      failures++;
      $display("FAIL pwm_random_bus got bus_err=%0d want 0", bus_err);
    end
    bus_err = 1'b0;
  endtask

  task automatic test_aw_wait();
    @(negedge tb_ACLK);
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b00) begin
        failures++;
        $display("FAIL aw_only_ready cycle %0d got %b want 00", i, {S_AXI_AWREADY, S_AXI_WREADY});
      end
      @(negedge tb_ACLK);
    end
    S_AXI_WVALID = 1'b1;
    #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== 3'b110) begin
      failures++;
      $display("FAIL aw_w_accept got ready/bvalid=%b want 110",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID});
    end
    @(posedge tb_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    model[1] = 32'h55;
    @(negedge tb_ACLK);
    checks++;
    if (S_AXI_BVALID !== 1'b1) begin
      failures++;
      $display("FAIL aw_w_bvalid got %b want 1", S_AXI_BVALID);
    end
    @(posedge tb_ACLK); #1;
  endtask

  task automatic test_bresp_hold();
    logic [31:0] rd;
    logic [1:0]  resp;
    bit ok;
    @(negedge tb_ACLK);
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'hA1A1A1A1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    @(posedge tb_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(negedge tb_ACLK);
    // Second write presented while the first response is still pending
    S_AXI_WDATA = 32'hB2B2B2B2; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b100) begin
        failures++;
        $display("FAIL bresp_hold cycle %0d got bvalid/awready/wready=%b want 100",
                 i, {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
      end
      @(negedge tb_ACLK);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge tb_ACLK); #1;
    checks++;
    if ({S_AXI_BVALID, S_AXI_AWREADY} !== 2'b01) begin
      failures++;
      $display("FAIL bresp_release got bvalid/awready=%b want 01", {S_AXI_BVALID, S_AXI_AWREADY});
    end
    @(posedge tb_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(posedge tb_ACLK); #1;
    model[2] = 32'hB2B2B2B2;
    axi_read(4'h8, rd, resp, ok);
    checks++;
    if (!ok || rd !== 32'hB2B2B2B2) begin
      failures++;
      $display("FAIL bresp_second_write got %h want b2b2b2b2", rd);
    end
  endtask

  task automatic test_simul_rw();
    logic [31:0] old_v;
    logic [31:0] rd;
    logic [1:0]  resp;
    bit ok;
    old_v = model[2];
    @(negedge tb_ACLK);
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'hC3C3_0000 ^ old_v; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = 4'h8; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_ARREADY} !== 2'b11) begin
      failures++;
      $display("FAIL simul_accept got awready/arready=%b want 11", {S_AXI_AWREADY, S_AXI_ARREADY});
    end
    @(posedge tb_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    model[2] = 32'hC3C3_0000 ^ old_v;
    @(negedge tb_ACLK);
    checks++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== old_v) begin
      failures++;
      $display("FAIL simul_old_value got rvalid=%b rdata=%h want 1 %h", S_AXI_RVALID, S_AXI_RDATA,
               old_v);
    end
    @(posedge tb_ACLK); #1;
    axi_read(4'h8, rd, resp, ok);
    checks++;
    if (!ok || rd !== model[2]) begin
      failures++;
      $display("FAIL simul_new_value got %h want %h", rd, model[2]);
    end
  endtask

  task automatic test_duty_change();
    int hl, hr, mid;
    bit prev, found;
    bit s [16];
    cfg_write(4'hC, 32'h0);
    cfg_write(4'h0, 32'd10);
    cfg_write(4'h4, 32'd3);
    cfg_write(4'hC, 32'h1);
    repeat (30) @(negedge tb_ACLK);
    // A falling edge on the left output means the counter now reads 4
    found = 1'b0;
    prev = motor_pwm[0];
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge tb_ACLK);
      if (prev && !motor_pwm[0]) found = 1'b1;
      else prev = motor_pwm[0];
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL duty_sync got no falling edge want one within 40 cycles");
    end
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'd7; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    @(posedge tb_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    model[1] = 32'd7;
    for (int i = 0; i < 16; i++) begin
      @(negedge tb_ACLK);
      s[i] = motor_pwm[0];
    end
    mid = 0;
    for (int i = 1; i <= 5; i++) mid += int'(s[i]);
    hl = 0;
    for (int i = 6; i < 16; i++) hl += int'(s[i]);
`ifdef PWM_CAR_SHADOW_EN
    hr = 0;
`else
    hr = 2;
`endif
    checks++;
    if (s[1] !== (hr != 0)) begin
      failures++;
      $display("FAIL duty_second_edge got %b want %b", s[1], hr != 0);
    end
    checks++;
    if (mid !== hr) begin
      failures++;
      $display("FAIL duty_rest_of_period got %0d high want %0d", mid, hr);
    end
    checks++;
    if (hl !== 7) begin
      failures++;
      $display("FAIL duty_next_period got %0d high want 7", hl);
    end
    checks++;
    if (bus_err !== 1'b0) begin
      failures++;
      $display("FAIL duty_bus got bus_err=%0d want 0", bus_err);
    end
    bus_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic [1:0]  resp;
    bit ok;
    cfg_write(4'h4, 32'd5);
    @(negedge tb_ACLK);
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h1234; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    @(posedge tb_ACLK); #1;
    checks++;
    if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid_pending got bvalid/rvalid=%b want 11", {S_AXI_BVALID, S_AXI_RVALID});
    end
    #2 ARESETN = 1'b0;
    #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
         S_AXI_RDATA, motor_pwm, motor_dir} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got aw=%b w=%b b=%b ar=%b r=%b rdata=%h want all 0",
               S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
               S_AXI_RDATA);
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    repeat (2) @(negedge tb_ACLK);
    ARESETN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd, resp, ok);
      checks++;
      if (!ok || rd !== model[i]) begin
        failures++;
        $display("FAIL rst_mid_regs reg %0d got %h want %h", i, rd, model[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plan_regs();
    test_random_regs();
    test_strobe();
    test_pwm_basic();
    test_pwm_random();
    test_aw_wait();
    test_bresp_hold();
    test_simul_rw();
    test_duty_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
